// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: owns the stack pointer, maps memory-class ops onto the data/stack memory
// and sequences the two-access INT/RTI ops. Define STACK_GUARD_EN to add the sticky stack_err output.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 11,
  parameter int unsigned FLAG_W = 3,
  parameter int unsigned RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_ea,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_pc_next,
  input  logic [FLAG_W-1:0] ex_flags,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic [MEM_AW-1:0] sp_o
`ifdef STACK_GUARD_EN
  , output logic            stack_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_INT2, S_RTI2} state_t;

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_PUSH  = 4'd3;
  localparam logic [3:0] OP_POP   = 4'd4;
  localparam logic [3:0] OP_CALL  = 4'd5;
  localparam logic [3:0] OP_RET   = 4'd6;
  localparam logic [3:0] OP_INT   = 4'd7;
  localparam logic [3:0] OP_RTI   = 4'd8;

  localparam logic [MEM_AW-1:0] SP_TOP  = {{(MEM_AW-1){1'b1}}, 1'b0};
  localparam logic [MEM_AW-1:0] SP_STEP = MEM_AW'(2);

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   sp_q, sp_d, sp_pop;
  logic                do_push, do_pop, push_ok, pop_ok;
  logic [DATA_W-1:0]   push_data;
  logic                want_wb, want_pc, want_flags;
  logic                cap_wb, cap_pc, cap_flags;

  logic                wb_we_q, pc_load_q, flags_load_q;
  logic [RD_W-1:0]     wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q, pc_value_q;
  logic [FLAG_W-1:0]   flags_value_q;

  assign sp_pop  = sp_q + SP_STEP;
  // Guard blocks a push into word 0 and a pop from an empty stack.
  assign push_ok = !(GUARD && (sp_q == '0));
  assign pop_ok  = !(GUARD && (sp_q == SP_TOP));

  // Op decode, memory request and next state
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall_o    = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    push_data  = '0;
    want_wb    = 1'b0;
    want_pc    = 1'b0;
    want_flags = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          case (ex_op)
            OP_LOAD:  begin mem_re = 1'b1; mem_addr = ex_ea; want_wb = 1'b1; end
            OP_STORE: begin mem_we = 1'b1; mem_addr = ex_ea; mem_wdata = ex_wdata; end
            OP_PUSH:  begin do_push = 1'b1; push_data = ex_wdata; end
            OP_POP:   begin do_pop = 1'b1; want_wb = 1'b1; end
            OP_CALL:  begin do_push = 1'b1; push_data = ex_pc_next; end
            OP_RET:   begin do_pop = 1'b1; want_pc = 1'b1; end
            OP_INT: begin
              do_push   = 1'b1;
              push_data = ex_pc_next;
              stall_o   = 1'b1;
              state_d   = S_INT2;
            end
            OP_RTI: begin
              do_pop     = 1'b1;
              want_flags = 1'b1;
              stall_o    = 1'b1;
              state_d    = S_RTI2;
            end
            default: ;
          endcase
        end
      end
      S_INT2: begin
        do_push   = 1'b1;
        push_data = DATA_W'(ex_flags);
        state_d   = S_IDLE;
      end
      S_RTI2: begin
        do_pop  = 1'b1;
        want_pc = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_push && push_ok) begin
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(sp_q);
      mem_wdata = push_data;
      sp_d      = sp_q - SP_STEP;
    end
    if (do_pop && pop_ok) begin
      mem_re   = 1'b1;
      mem_addr = ADDR_W'(sp_pop);
      sp_d     = sp_pop;
    end

    // A suppressed pop produces no result pulse.
    cap_wb    = want_wb    && !(do_pop && !pop_ok);
    cap_pc    = want_pc    && !(do_pop && !pop_ok);
    cap_flags = want_flags && !(do_pop && !pop_ok);

    if (rst) begin
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      stall_o = 1'b0;
    end
  end

  // State, SP and MEM/WB result registers; read data captured at the rise ending the access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sp_q          <= SP_TOP;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      pc_load_q     <= 1'b0;
      pc_value_q    <= '0;
      flags_load_q  <= 1'b0;
      flags_value_q <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      wb_we_q      <= cap_wb;
      pc_load_q    <= cap_pc;
      flags_load_q <= cap_flags;
      if (cap_wb) begin
        wb_rd_q   <= ex_rd;
        wb_data_q <= mem_rdata;
      end
      if (cap_pc)    pc_value_q    <= mem_rdata;
      if (cap_flags) flags_value_q <= mem_rdata[FLAG_W-1:0];
    end
  end

  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign pc_load     = pc_load_q;
  assign pc_value    = pc_value_q;
  assign flags_load  = flags_load_q;
  assign flags_value = flags_value_q;
  assign sp_o        = sp_q;

`ifdef STACK_GUARD_EN
  logic stack_err_q;

  // Sticky over/underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_err_q <= 1'b0;
    end else if ((do_push && !push_ok) || (do_pop && !pop_ok)) begin
      stack_err_q <= 1'b1;
    end
  end

  assign stack_err = stack_err_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: reference stack/memory model, result scoreboard and a behavioural
// 16-bit-word memory (write on rise, read on fall). Honours STACK_GUARD_EN when defined.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_ea, ex_wdata, ex_pc_next;
  logic [2:0]  ex_flags, ex_rd;
  logic        mem_we, mem_re, stall_o;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_we, pc_load, flags_load;
  logic [2:0]  wb_rd, flags_value;
  logic [31:0] wb_data, pc_value;
  logic [10:0] sp_o;
`ifdef STACK_GUARD_EN
  logic        stack_err;
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_ea(ex_ea),
    .ex_wdata(ex_wdata), .ex_pc_next(ex_pc_next), .ex_flags(ex_flags), .ex_rd(ex_rd),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_o(stall_o), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .pc_load(pc_load), .pc_value(pc_value), .flags_load(flags_load),
    .flags_value(flags_value), .sp_o(sp_o)
`ifdef STACK_GUARD_EN
    , .stack_err(stack_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural memory, low 16-bit word at addr, high word at addr+1
  logic [15:0] pmem [0:2047];
  logic [10:0] pa0, pa1;
  assign pa0 = mem_addr[10:0];
  assign pa1 = pa0 + 11'd1;
  always @(posedge clk) if (mem_we) begin
    pmem[pa0] <= mem_wdata[15:0];
    pmem[pa1] <= mem_wdata[31:16];
  end
  always @(negedge clk) mem_rdata <= mem_re ? {pmem[pa1], pmem[pa0]} : 32'hzzzz_zzzz;

  // Reference model state
  logic [15:0] mm [0:2047];
  logic [10:0] m_sp = 11'h7FE;
  int          m_state = 0;
  logic        m_err = 1'b0;
  logic        mon_en = 1'b0;

  typedef struct {
    int          kind;
    logic [2:0]  rd;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [10:0] a);
    logic [10:0] a1;
    a1 = a + 11'd1;
    return {mm[a1], mm[a]};
  endfunction

  task automatic mwrite(input logic [10:0] a, input logic [31:0] d);
    logic [10:0] a1;
    a1 = a + 11'd1;
    mm[a]  = d[15:0];
    mm[a1] = d[31:16];
  endtask

  // One clock cycle: drive inputs, predict, check combinational outputs at the falling edge
  task automatic do_op(input logic r, input logic v, input logic [3:0] op, input logic [31:0] ea,
                       input logic [31:0] wd, input logic [31:0] pcn, input logic [2:0] fl,
                       input logic [2:0] rd);
    logic        e_we, e_re, e_st, psh, pp, err_prev;
    logic [31:0] e_addr, e_wd, pd;
    logic [10:0] sp_prev, a;
    int          kind;
    sb_t         ent;
    e_we = 1'b0; e_re = 1'b0; e_st = 1'b0; psh = 1'b0; pp = 1'b0;
    e_addr = '0; e_wd = '0; pd = '0; kind = -1; a = '0;
    sp_prev = m_sp; err_prev = m_err;
    rst = r; ex_valid = v; ex_op = op; ex_ea = ea; ex_wdata = wd;
    ex_pc_next = pcn; ex_flags = fl; ex_rd = rd;
    if (r) begin
      m_state = 0; m_sp = 11'h7FE; m_err = 1'b0;
    end else begin
      case (m_state)
        0: if (v) begin
          case (op)
            4'd1: begin e_re = 1'b1; e_addr = ea; kind = 0; end
            4'd2: begin e_we = 1'b1; e_addr = ea; e_wd = wd; mwrite(ea[10:0], wd); end
            4'd3: begin psh = 1'b1; pd = wd; end
            4'd4: begin pp = 1'b1; kind = 0; end
            4'd5: begin psh = 1'b1; pd = pcn; end
            4'd6: begin pp = 1'b1; kind = 1; end
            4'd7: begin psh = 1'b1; pd = pcn; e_st = 1'b1; m_state = 1; end
            4'd8: begin pp = 1'b1; kind = 2; e_st = 1'b1; m_state = 2; end
            default: ;
          endcase
        end
        1: begin psh = 1'b1; pd = 32'(fl); m_state = 0; end
        default: begin pp = 1'b1; kind = 1; m_state = 0; end
      endcase
      if (psh) begin
        if (GUARD && m_sp == 11'h000) m_err = 1'b1;
        else begin
          e_we = 1'b1; e_addr = 32'(m_sp); e_wd = pd;
          mwrite(m_sp, pd);
          m_sp = m_sp - 11'd2;
        end
      end
      if (pp) begin
        a = m_sp + 11'd2;
        if (GUARD && m_sp == 11'h7FE) begin
          m_err = 1'b1; kind = -1;
        end else begin
          e_re = 1'b1; e_addr = 32'(a); m_sp = a;
        end
      end
      if (kind >= 0) begin
        ent.kind = kind; ent.rd = rd; ent.data = mread(e_addr[10:0]);
        sbq.push_back(ent);
      end
    end
    @(negedge clk);
    check_eq("mem_we", 64'(mem_we), 64'(e_we));
    check_eq("mem_re", 64'(mem_re), 64'(e_re));
    check_eq("stall_o", 64'(stall_o), 64'(e_st));
    if (e_we || e_re) check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
    if (e_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    if (!r) check_eq("sp_o", 64'(sp_o), 64'(sp_prev));
`ifdef STACK_GUARD_EN
    if (!r) check_eq("stack_err", 64'(stack_err), 64'(err_prev));
`endif
    @(posedge clk);
    #1;
  endtask

  // Result pulses popped against the scoreboard
  always @(negedge clk) begin
    sb_t e;
    if (mon_en && (wb_we || pc_load || flags_load)) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_pulse", 64'({wb_we, pc_load, flags_load}), 64'd0);
      end else begin
        e = sbq.pop_front();
        check_eq("pulse_kind", 64'({wb_we, pc_load, flags_load}), 64'(3'b100 >> e.kind));
        if (e.kind == 0) begin
          check_eq("wb_rd", 64'(wb_rd), 64'(e.rd));
          check_eq("wb_data", 64'(wb_data), 64'(e.data));
        end else if (e.kind == 1) begin
          check_eq("pc_value", 64'(pc_value), 64'(e.data));
        end else begin
          check_eq("flags_value", 64'(flags_value), 64'(e.data[2:0]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      pmem[i] = '0;
      mm[i]   = '0;
    end
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_ea = '0; ex_wdata = '0;
    ex_pc_next = '0; ex_flags = '0; ex_rd = '0;
    @(posedge clk);
    #1;
    do_op(1, 0, 4'd0, 0, 0, 0, 0, 0);
    do_op(1, 0, 4'd0, 0, 0, 0, 0, 0);
    check_eq("rst_sp", 64'(sp_o), 64'h7FE);
    check_eq("rst_wb_we", 64'(wb_we), 64'd0);
    check_eq("rst_wb_data", 64'(wb_data), 64'd0);
    check_eq("rst_pc_load", 64'(pc_load), 64'd0);
    check_eq("rst_pc_value", 64'(pc_value), 64'd0);
    check_eq("rst_flags_load", 64'(flags_load), 64'd0);
    mon_en = 1'b1;

`ifdef STACK_GUARD_EN
    do_op(0, 1, 4'd4, 0, 0, 0, 0, 3'd2);
    do_op(0, 0, 4'd0, 0, 0, 0, 0, 0);
    check_eq("guard_err_set", 64'(stack_err), 64'd1);
    do_op(1, 0, 4'd0, 0, 0, 0, 0, 0);
`endif

    do_op(0, 1, 4'd3, 0, 32'hDEADBEEF, 0, 0, 0);
    do_op(0, 1, 4'd4, 0, 0, 0, 0, 3'd2);
    do_op(0, 1, 4'd2, 32'h10, 32'h12345678, 0, 0, 0);
    do_op(0, 1, 4'd1, 32'h10, 0, 0, 0, 3'd5);
    do_op(0, 1, 4'd7, 0, 0, 32'h40, 3'b101, 0);
    do_op(0, 0, 4'd0, 0, 0, 0, 3'b101, 0);
    do_op(0, 1, 4'd8, 0, 0, 0, 0, 0);
    do_op(0, 1, 4'd3, 0, 32'h5555, 0, 0, 0);
    do_op(0, 1, 4'd5, 0, 0, 32'h22, 0, 0);
    do_op(0, 1, 4'd6, 0, 0, 0, 0, 0);
    do_op(0, 0, 4'd4, 0, 0, 0, 0, 0);
    do_op(0, 1, 4'd11, 0, 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      do_op(0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            $urandom, $urandom, $urandom, 3'($urandom), 3'($urandom));
    end
    do_op(0, 0, 4'd0, 0, 0, 0, 0, 0);

    while (m_sp != 11'h000) do_op(0, 1, 4'd3, 0, 32'(m_sp), 0, 0, 0);
    do_op(0, 1, 4'd3, 0, 32'hCAFE0000, 0, 0, 0);
    do_op(0, 1, 4'd4, 0, 0, 0, 0, 3'd1);
    do_op(0, 1, 4'd4, 0, 0, 0, 0, 3'd3);

    do_op(1, 0, 4'd0, 0, 0, 0, 0, 0);
    do_op(0, 1, 4'd7, 0, 0, 32'h40, 3'b101, 0);
    do_op(1, 0, 4'd0, 0, 0, 0, 3'b101, 0);
    do_op(0, 0, 4'd0, 0, 0, 0, 0, 0);
    check_eq("rst_int2_sp", 64'(sp_o), 64'h7FE);
    check_eq("rst_int2_stall", 64'(stall_o), 64'd0);

    do_op(0, 0, 4'd0, 0, 0, 0, 0, 0);
    do_op(0, 0, 4'd0, 0, 0, 0, 0, 0);
    check_eq("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
